// File: rtl/multicycle_control_pkg.sv
// Shared O9 definitions: opcodes, FSM state encodings, datapath select codes and
// the layout of the control word that the sequencer drives into the datapath.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam int RETIRED_W = 16;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_MADDR  = 4'd4,
        S_MRD    = 4'd5,
        S_MWB    = 4'd6,
        S_MWR    = 4'd7,
        S_EXEC   = 4'd8,
        S_RWB    = 4'd9,
        S_AEXEC  = 4'd10,
        S_AWB    = 4'd11,
        S_BEQ    = 4'd12,
        S_JUMP   = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_ONE     = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_source_t;

    // 16-bit control word, MSB first in the order the datapath strobes are listed.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
    } ctrl_word_t;

    // States whose exit edge completes an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MWB) || (s == S_MWR) || (s == S_RWB) ||
               (s == S_AWB) || (s == S_BEQ) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/control_word_rom.sv
// Combinational state -> control word table for the O9 multicycle sequencer.
// S_INIT, S_HALT and unused encodings produce an all-zero word.
module control_word_rom
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path infers a latch.
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read = 1'b1;
            end
            S_FETCH2: begin
                cw.mem_read  = 1'b1;
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
                cw.alu_src_b = SRCB_ONE;
                cw.alu_op    = ALU_ADD;
                cw.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
            end
            S_MADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            // Address operands are held through the memory states so the
            // combinational address stays stable for the synchronous RAM.
            S_MRD: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.iord      = 1'b1;
                cw.mem_read  = 1'b1;
            end
            S_MWB: begin
                cw.alu_src_a  = 1'b1;
                cw.alu_src_b  = SRCB_IMM;
                cw.iord       = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
            end
            S_MWR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALU_FUNCT;
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
            end
            S_AEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            S_AWB: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.reg_write = 1'b1;
            end
            S_BEQ: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRCB_B;
                cw.alu_op        = ALU_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PCSRC_JUMP;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the O9 multicycle datapath: state register, next-state
// logic and retired-instruction counter; strobes come from control_word_rom.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = RETIRED_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_word_t       cw;

    // Reset forces S_INIT asynchronously, whose control word is all zero, so every
    // strobe drops the moment reset goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from pre-edge values.
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_HALT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_AEXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MADDR:  state_d = (opCode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:    state_d = S_MWB;
            S_MWB:    state_d = S_FETCH;
            S_MWR:    state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_AEXEC:  state_d = S_AWB;
            S_AWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Counts on the edge leaving a retire state; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (is_retire_state(state_q)) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    control_word_rom u_rom (
        .state (state_q),
        .cw    (cw)
    );

    assign PCWrite     = cw.pc_write;
    assign PCWriteCond = cw.pc_write_cond;
    assign IorD        = cw.iord;
    assign MemRead     = cw.mem_read;
    assign MemWrite    = cw.mem_write;
    assign MemtoReg    = cw.mem_to_reg;
    assign IRWrite     = cw.ir_write;
    assign RegWrite    = cw.reg_write;
    assign RegDst      = cw.reg_dst;
    assign ALUSrcA     = cw.alu_src_a;
    assign ALUSrcB     = cw.alu_src_b;
    assign ALUOp       = cw.alu_op;
    assign PCSource    = cw.pc_source;
    assign halted      = (state_q == S_HALT);
    assign retired     = retired_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: random instruction mix against a
// per-instruction step model, plus reset, halt, abort and counter-wrap scenarios.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [15:0] retired;
    logic [3:0] state_dbg;

    logic       w_pcw, w_pcwc, w_iord, w_mrd, w_mwr, w_m2r, w_irw, w_rw, w_rdst, w_srca, w_halted;
    logic [1:0] w_srcb, w_aluop, w_pcsrc;
    logic [1:0] w_retired;
    logic [3:0] w_state;

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opCode(opcode),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord),
        .MemRead(mem_read), .MemWrite(mem_write), .MemtoReg(mem_to_reg),
        .IRWrite(ir_write), .RegWrite(reg_write), .RegDst(reg_dst),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op),
        .PCSource(pc_source), .halted(halted), .retired(retired),
        .state_dbg(state_dbg)
    );

    // Narrow-counter copy: same stimulus, exercises the wrap to zero quickly.
    multicycle_control #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .opCode(opcode),
        .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IorD(w_iord),
        .MemRead(w_mrd), .MemWrite(w_mwr), .MemtoReg(w_m2r),
        .IRWrite(w_irw), .RegWrite(w_rw), .RegDst(w_rdst),
        .ALUSrcA(w_srca), .ALUSrcB(w_srcb), .ALUOp(w_aluop),
        .PCSource(w_pcsrc), .halted(w_halted), .retired(w_retired),
        .state_dbg(w_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       halted;
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } obs_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state_dbg;     o.halted = halted;
        o.pcw = pc_write;     o.pcwc = pc_write_cond; o.iord = iord;
        o.mrd = mem_read;     o.mwr = mem_write;      o.m2r = mem_to_reg;
        o.irw = ir_write;     o.rw = reg_write;       o.rdst = reg_dst;
        o.srca = alu_src_a;   o.srcb = alu_src_b;     o.aluop = alu_op;
        o.pcsrc = pc_source;
        return o;
    endfunction

    // Expected strobes for one datapath step, written straight from the state table.
    function automatic obs_t expect_out(input state_t s);
        obs_t e;
        e = '0;
        e.st = s;
        case (s)
            S_FETCH:  e.mrd = 1'b1;
            S_FETCH2: begin e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b01; end
            S_DECODE: e.srcb = 2'b10;
            S_MADDR:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            S_MRD:    begin e.srca = 1'b1; e.srcb = 2'b10; e.iord = 1'b1; e.mrd = 1'b1; end
            S_MWB:    begin e.srca = 1'b1; e.srcb = 2'b10; e.iord = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; end
            S_MWR:    begin e.srca = 1'b1; e.srcb = 2'b10; e.iord = 1'b1; e.mwr = 1'b1; end
            S_EXEC:   begin e.srca = 1'b1; e.aluop = 2'b10; end
            S_RWB:    begin e.srca = 1'b1; e.aluop = 2'b10; e.rdst = 1'b1; e.rw = 1'b1; end
            S_AEXEC:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            S_AWB:    begin e.srca = 1'b1; e.srcb = 2'b10; e.rw = 1'b1; end
            S_BEQ:    begin e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
            S_JUMP:   begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
            S_HALT:   e.halted = 1'b1;
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic check_retired(input string tag);
        check({tag, " retired"}, 32'(retired), 32'(exp_retired % 65536));
        check({tag, " retired_w"}, 32'(w_retired), 32'(exp_retired % 4));
    endtask

    // Called at a negedge with the DUT in S_FETCH; ends at the negedge after the
    // last step (back in S_FETCH, or still in S_HALT).
    task automatic run_instr(input logic [5:0] op, input string name);
        state_t seq[$];
        opcode = op;
        seq.push_back(S_FETCH);
        seq.push_back(S_FETCH2);
        seq.push_back(S_DECODE);
        case (op)
            OP_LW:    begin seq.push_back(S_MADDR); seq.push_back(S_MRD); seq.push_back(S_MWB); end
            OP_SW:    begin seq.push_back(S_MADDR); seq.push_back(S_MWR); end
            OP_RTYPE: begin seq.push_back(S_EXEC);  seq.push_back(S_RWB); end
            OP_ADDI:  begin seq.push_back(S_AEXEC); seq.push_back(S_AWB); end
            OP_BEQ:   seq.push_back(S_BEQ);
            OP_J:     seq.push_back(S_JUMP);
            default:  seq.push_back(S_HALT);
        endcase
        foreach (seq[i]) begin
            check($sformatf("%s step%0d", name, i), 32'(sample()), 32'(expect_out(seq[i])));
            @(negedge clk);
        end
        if (seq[seq.size()-1] != S_HALT) exp_retired++;
        check_retired(name);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset low outputs", 32'(sample()), 32'(obs_t'('0)));
        end
        exp_retired = 0;
        check_retired("reset low");
        reset = 1'b1;
        check("after release init", 32'(sample()), 32'(expect_out(S_INIT)));
        @(negedge clk);
    endtask

    task automatic hold_halt(input string name);
        repeat (20) begin
            check({name, " halt hold"}, 32'(sample()), 32'(expect_out(S_HALT)));
            @(negedge clk);
        end
        check_retired({name, " halt"});
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};

        do_reset();
        run_instr(OP_LW, "lw");
        run_instr(OP_BEQ, "beq");
        run_instr(OP_J, "j");
        run_instr(OP_RTYPE, "rtype");
        run_instr(OP_ADDI, "addi");
        run_instr(OP_SW, "sw");

        for (int n = 0; n < 40; n++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], $sformatf("rand%0d", n));
        end

        run_instr(OP_HALT, "halt");
        hold_halt("op111111");
        do_reset();
        run_instr(6'b010101, "illegal");
        hold_halt("op010101");
        do_reset();

        // Abort a store in its write cycle: MemWrite must fall with reset, not at an edge.
        run_instr(OP_ADDI, "pre_abort");
        opcode = OP_SW;
        repeat (4) @(negedge clk);
        check("abort in mwr", 32'(sample()), 32'(expect_out(S_MWR)));
        #1 reset = 1'b0;
        #1 check("abort async drop", 32'(sample()), 32'(expect_out(S_INIT)));
        exp_retired = 0;
        check_retired("abort");
        @(negedge clk);
        reset = 1'b1;
        check("abort release init", 32'(sample()), 32'(expect_out(S_INIT)));
        @(negedge clk);
        run_instr(OP_LW, "post_abort_lw");
        for (int n = 0; n < 6; n++) begin
            run_instr(OP_ADDI, $sformatf("wrap%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
